// File: rtl/iob_irq_pending.sv
// iob_irq_pending: request-collection stage in front of iob_prio_enc.
// Each raw request line is optionally synchronized, then handled either as a
// level (follows the line) or as a rising edge latched until acknowledged.
// The enabled pending vector, its OR and a sticky per-line overflow flag are
// registered outputs.
module iob_irq_pending #(
    parameter int W    = 8,
    parameter int SYNC = 0
) (
    input  logic                 clk_i,
    input  logic                 cke_i,
    input  logic                 rst_n_i,
    input  logic [W-1:0]         req_i,
    input  logic [W-1:0]         level_i,
    input  logic [W-1:0]         en_i,
    input  logic                 ack_i,
    input  logic [$clog2(W)-1:0] ack_idx_i,
    output logic [W-1:0]         pending_o,
    output logic                 any_o,
    output logic [W-1:0]         ovf_o
);

    localparam int IW = $clog2(W);

    logic [W-1:0] s;        // request lines after the synchronizer
    logic [W-1:0] prev_q;   // previous sample of s, for edge detection
    logic [W-1:0] l_q;      // sticky edge latch
    logic [W-1:0] l_d;
    logic [W-1:0] pend_q;
    logic [W-1:0] pend_d;
    logic         any_q;
    logic         any_d;
    logic [W-1:0] ovf_q;
    logic [W-1:0] ovf_d;
    logic [W-1:0] rise;
    logic [W-1:0] set;
    logic [W-1:0] clr;
    logic [W-1:0] raw_d;

    generate
        if (SYNC == 0) begin : g_nosync
            assign s = req_i;
        end else begin : g_sync
            logic [SYNC-1:0][W-1:0] sync_q;

            // Shift register delaying req_i by SYNC enabled cycles.
            always_ff @(posedge clk_i) begin
                // NOTE: clocked state uses non-blocking assignments so every
                // stage samples the value from before this edge.
                if (cke_i) begin
                    if (!rst_n_i) begin
                        sync_q <= '0;
                    end else begin
                        sync_q[0] <= req_i;
                        for (int i = 1; i < SYNC; i++) begin
                            sync_q[i] <= sync_q[i-1];
                        end
                    end
                end
            end

            assign s = sync_q[SYNC-1];
        end
    endgenerate

    // Next-state logic: edge detect, latch set/clear, masking and overflow.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch or
        // loop, so no path leaves one unassigned and no latch is inferred.
        rise = s & ~prev_q;
        set  = rise & ~level_i;
        clr  = '0;
        for (int b = 0; b < W; b++) begin
            // An index with no matching line (>= W) clears nothing.
            clr[b] = ack_i && (ack_idx_i == IW'(b));
        end
        // Set beats a simultaneous clear so a fresh edge is never lost.
        l_d    = set | (l_q & ~clr);
        raw_d  = (level_i & s) | (~level_i & l_d);
        pend_d = raw_d & en_i;
        any_d  = |pend_d;
        // A second edge on an already latched line is an overflow, unless the
        // same cycle also acknowledges it (then exactly one event remains).
        ovf_d  = (set & l_q & ~clr) | (ovf_q & ~clr);
    end

    // State and output registers; reset only takes effect on enabled edges.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (!rst_n_i) begin
                prev_q <= '0;
                l_q    <= '0;
                pend_q <= '0;
                any_q  <= 1'b0;
                ovf_q  <= '0;
            end else begin
                prev_q <= s;
                l_q    <= l_d;
                pend_q <= pend_d;
                any_q  <= any_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign pending_o = pend_q;
    assign any_o     = any_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_iob_irq_pending.sv
// Testbench for iob_irq_pending: one instance with SYNC=0 for the functional
// scenarios and one with SYNC=2 for synchronizer latency and stall behaviour.
module tb_iob_irq_pending;

    typedef struct {
        logic       rst;
        logic       cke;
        logic [7:0] en;
        logic [7:0] req;
        logic       ack;
        logic [2:0] idx;
        logic [7:0] pend;
        logic [7:0] ovf;
    } row_t;

    typedef struct {
        string      name;
        logic [7:0] pend;
        logic [7:0] ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       cke = 1'b1;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] level = 8'h00;
    logic [7:0] en = 8'hFF;
    logic       ack = 1'b0;
    logic [2:0] ack_idx = 3'd0;
    logic [7:0] pending;
    logic       any;
    logic [7:0] ovf;

    logic       cke2 = 1'b1;
    logic       rst2_n = 1'b0;
    logic [7:0] req2 = 8'h00;
    logic       ack2 = 1'b0;
    logic [2:0] ack_idx2 = 3'd0;
    logic [7:0] pending2;
    logic       any2;
    logic [7:0] ovf2;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    iob_irq_pending #(.W(8), .SYNC(0)) dut0 (
        .clk_i     (clk),
        .cke_i     (cke),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .level_i   (level),
        .en_i      (en),
        .ack_i     (ack),
        .ack_idx_i (ack_idx),
        .pending_o (pending),
        .any_o     (any),
        .ovf_o     (ovf)
    );

    iob_irq_pending #(.W(8), .SYNC(2)) dut2 (
        .clk_i     (clk),
        .cke_i     (cke2),
        .rst_n_i   (rst2_n),
        .req_i     (req2),
        .level_i   (level),
        .en_i      (en),
        .ack_i     (ack2),
        .ack_idx_i (ack_idx2),
        .pending_o (pending2),
        .any_o     (any2),
        .ovf_o     (ovf2)
    );

    function automatic row_t mk(input logic r, input logic c, input logic [7:0] e,
                                input logic [7:0] q, input logic a, input logic [2:0] i,
                                input logic [7:0] p, input logic [7:0] o);
        row_t t;
        t.rst = r; t.cke = c; t.en = e; t.req = q;
        t.ack = a; t.idx = i; t.pend = p; t.ovf = o;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one row into dut0 and queue its expected post-edge result.
    task automatic drive(input row_t r, input string nm);
        exp_t e;
        rst_n = r.rst; cke = r.cke; en = r.en; req = r.req;
        ack = r.ack; ack_idx = r.idx;
        e.name = nm; e.pend = r.pend; e.ovf = r.ovf;
        sb_q.push_back(e);
    endtask

    // Drive one row into dut2 (enable mask is shared) and queue its result.
    task automatic drive2(input row_t r, input string nm);
        exp_t e;
        rst2_n = r.rst; cke2 = r.cke; en = r.en; req2 = r.req;
        ack2 = r.ack; ack_idx2 = r.idx;
        e.name = nm; e.pend = r.pend; e.ovf = r.ovf;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        level = 8'h00;
        rows.push_back(mk(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00));
        rows.push_back(mk(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00));
        // Line held high through reset registers one edge after release.
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 3'd0, 8'hFF, 8'h00));
        for (int i = 0; i < 8; i++) begin
            logic [7:0] left;
            left = 8'hFF << (i + 1);
            rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 3'(i), left, 8'h00));
        end
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i], $sformatf("reset[%0d]", i));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (pending !== e.pend || any !== (|e.pend) || ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s: pending=%h any=%b ovf=%h, expected pending=%h any=%b ovf=%h",
                         e.name, pending, any, ovf, e.pend, |e.pend, e.ovf);
            end
        end
    endtask

    task automatic test_edge_capture();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h20, 1'b0, 3'd0, 8'h20, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h20, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h20, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd5, 8'h00, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i], $sformatf("edge[%0d]", i));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (pending !== e.pend || any !== (|e.pend) || ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s: pending=%h any=%b ovf=%h, expected pending=%h any=%b ovf=%h",
                         e.name, pending, any, ovf, e.pend, |e.pend, e.ovf);
            end
        end
    endtask

    task automatic test_collision();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h04, 1'b0, 3'd0, 8'h04, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00));
        // New rise plus ack of the same bit: stays pending, no overflow.
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h04, 1'b1, 3'd2, 8'h04, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h04, 8'h00));
        // Rise on an already latched bit without ack: overflow.
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h04, 1'b0, 3'd0, 8'h04, 8'h04));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h04, 8'h04));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd2, 8'h00, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i], $sformatf("collision[%0d]", i));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (pending !== e.pend || any !== (|e.pend) || ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s: pending=%h any=%b ovf=%h, expected pending=%h any=%b ovf=%h",
                         e.name, pending, any, ovf, e.pend, |e.pend, e.ovf);
            end
        end
    endtask

    task automatic test_level();
        row_t rows[$];
        exp_t e;
        level = 8'h01;
        for (int i = 0; i < 3; i++) begin
            rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, 3'd0, 8'h01, 8'h00));
        end
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i], $sformatf("level[%0d]", i));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (pending !== e.pend || any !== (|e.pend) || ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s: pending=%h any=%b ovf=%h, expected pending=%h any=%b ovf=%h",
                         e.name, pending, any, ovf, e.pend, |e.pend, e.ovf);
            end
        end
        level = 8'h00;
    endtask

    task automatic test_mask();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1'b1, 1'b1, 8'hBF, 8'h42, 1'b0, 3'd0, 8'h02, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hBF, 8'h00, 1'b0, 3'd0, 8'h02, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h42, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd1, 8'h40, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd6, 8'h00, 8'h00));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i], $sformatf("mask[%0d]", i));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (pending !== e.pend || any !== (|e.pend) || ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s: pending=%h any=%b ovf=%h, expected pending=%h any=%b ovf=%h",
                         e.name, pending, any, ovf, e.pend, |e.pend, e.ovf);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_stall();
        row_t rows[$];
        exp_t e;
        // Edge arriving while stalled is seen once the clock enable returns.
        rows.push_back(mk(1'b1, 1'b0, 8'hFF, 8'h10, 1'b0, 3'd0, 8'h00, 8'h00));
        rows.push_back(mk(1'b1, 1'b0, 8'hFF, 8'h10, 1'b0, 3'd0, 8'h00, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h10, 1'b0, 3'd0, 8'h10, 8'h00));
        // Reset is ignored while the clock enable is low.
        rows.push_back(mk(1'b0, 1'b0, 8'hFF, 8'h10, 1'b0, 3'd0, 8'h10, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd4, 8'h00, 8'h00));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i], $sformatf("stall[%0d]", i));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (pending !== e.pend || any !== (|e.pend) || ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s: pending=%h any=%b ovf=%h, expected pending=%h any=%b ovf=%h",
                         e.name, pending, any, ovf, e.pend, |e.pend, e.ovf);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_sync();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00));
        rows.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00));
        // One-cycle pulse on bit 3: visible three edges later.
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h08, 1'b0, 3'd0, 8'h00, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h08, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd3, 8'h00, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00));
        // Same pulse with a four-cycle stall after the first sync stage.
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h08, 1'b0, 3'd0, 8'h00, 8'h00));
        for (int i = 0; i < 4; i++) begin
            rows.push_back(mk(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00));
        end
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h08, 8'h00));
        rows.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 3'd3, 8'h00, 8'h00));
        for (int i = 0; i < rows.size(); i++) begin
            drive2(rows[i], $sformatf("sync2[%0d]", i));
            tick();
            e = sb_q.pop_front();
            checks++;
            if (pending2 !== e.pend || any2 !== (|e.pend) || ovf2 !== e.ovf) begin
                errors++;
                $display("FAIL %s: pending=%h any=%b ovf=%h, expected pending=%h any=%b ovf=%h",
                         e.name, pending2, any2, ovf2, e.pend, |e.pend, e.ovf);
            end
        end
        ack2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_edge_capture();
        test_collision();
        test_level();
        test_mask();
        test_stall();
        test_sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
